// File: rtl/btn_conditioner.sv
// btn_conditioner: two-flop synchroniser and 4-state debounce FSM that emits press/release pulses,
// a debounced level and a one-shot long-press pulse. Define BTN_AUTO_REPEAT_EN for auto-repeat of down.
module btn_conditioner #(
  parameter int unsigned            COUNT_WIDTH   = 32,
  parameter logic [COUNT_WIDTH-1:0] MAX_BTN_COUNT = COUNT_WIDTH'(2000000),
  parameter logic [COUNT_WIDTH-1:0] LONG_COUNT    = COUNT_WIDTH'(12000000),
  parameter logic [COUNT_WIDTH-1:0] REPEAT_COUNT  = COUNT_WIDTH'(2400000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic down,
  output logic up,
  output logic is_down,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] DEB_LAST  = MAX_BTN_COUNT - COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] LONG_LAST = LONG_COUNT - COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  logic                   r_s1;
  logic                   r_s_btn;
  state_t                 r_state;
  state_t                 w_state_nx;
  logic [COUNT_WIDTH-1:0] r_deb_cnt;
  logic [COUNT_WIDTH-1:0] w_deb_cnt_nx;
  logic [COUNT_WIDTH-1:0] r_hold_cnt;
  logic [COUNT_WIDTH-1:0] w_hold_cnt_nx;
  logic                   r_down;
  logic                   w_down_nx;
  logic                   r_up;
  logic                   w_up_nx;
  logic                   r_is_down;
  logic                   w_is_down_nx;
  logic                   r_long;
  logic                   w_long_nx;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [COUNT_WIDTH-1:0] REP_LAST = REPEAT_COUNT - COUNT_WIDTH'(1);
  logic [COUNT_WIDTH-1:0] r_rep_cnt;
  logic [COUNT_WIDTH-1:0] w_rep_cnt_nx;
`else
  // REPEAT_COUNT has no effect in this build; the empty check keeps the parameter referenced.
  if (REPEAT_COUNT == '0) begin : g_repeat_count_zero
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s_btn <= 1'b0;
    end else begin
      r_s1    <= btn;
      r_s_btn <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_down     <= 1'b0;
      r_up       <= 1'b0;
      r_is_down  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_deb_cnt  <= w_deb_cnt_nx;
      r_hold_cnt <= w_hold_cnt_nx;
      r_down     <= w_down_nx;
      r_up       <= w_up_nx;
      r_is_down  <= w_is_down_nx;
      r_long     <= w_long_nx;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= w_rep_cnt_nx;
    end
  end
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_deb_cnt_nx  = r_deb_cnt;
    w_hold_cnt_nx = r_hold_cnt;
    w_down_nx     = 1'b0;
    w_up_nx       = 1'b0;
    w_long_nx     = 1'b0;
    w_is_down_nx  = r_is_down;
`ifdef BTN_AUTO_REPEAT_EN
    w_rep_cnt_nx  = r_rep_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (r_s_btn) begin
          w_state_nx   = PRESS_WAIT;
          w_deb_cnt_nx = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_s_btn) begin
          w_state_nx = IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nx    = PRESSED;
          w_down_nx     = 1'b1;
          w_is_down_nx  = 1'b1;
          w_hold_cnt_nx = '0;
`ifdef BTN_AUTO_REPEAT_EN
          w_rep_cnt_nx  = '0;
`endif
        end else begin
          w_deb_cnt_nx = r_deb_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!r_s_btn) begin
          w_state_nx   = RELEASE_WAIT;
          w_deb_cnt_nx = '0;
        end else begin
          // hold_cnt parks at LONG_COUNT, which both stops the count and marks long_press as spent
          if (r_hold_cnt == LONG_COUNT) begin
            w_hold_cnt_nx = r_hold_cnt;
          end else begin
            w_hold_cnt_nx = r_hold_cnt + CNT_ONE;
          end
          if (r_hold_cnt == LONG_LAST) begin
            w_long_nx = 1'b1;
          end
`ifdef BTN_AUTO_REPEAT_EN
          if (r_hold_cnt == LONG_COUNT) begin
            if (r_rep_cnt == REP_LAST) begin
              w_down_nx    = 1'b1;
              w_rep_cnt_nx = '0;
            end else begin
              w_rep_cnt_nx = r_rep_cnt + CNT_ONE;
            end
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (r_s_btn) begin
          w_state_nx = PRESSED;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nx    = IDLE;
          w_up_nx       = 1'b1;
          w_is_down_nx  = 1'b0;
          w_hold_cnt_nx = '0;
        end else begin
          w_deb_cnt_nx = r_deb_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign down       = r_down;
  assign up         = r_up;
  assign is_down    = r_is_down;
  assign long_press = r_long;

endmodule
